tt_um_light_fp8: RTL and testbench
==================================

Name: tt_um_light_fp8

Overview:
- Registered FP8 multiplier on the standard 8-in/8-out/8-bidir user-project pin interface.
- Multiplies two OCP E4M3 (FN variant) operands, one on ui_in and one on uio_in, and drives the rounded E4M3 product on uo_out.
- Single-stage pipeline: one result per clock, output registered.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  reset; synchronous, active-high: rst_n=1 at a rising clk edge resets the block (fixed polarity despite the port name)
- ena  input  1  design enable; 1 = output register loads each cycle, 0 = output register holds
- ui_in  input  8  operand A, E4M3
- uio_in  input  8  operand B, E4M3 (bidir pins are used as inputs only)
- uo_out  output  8  registered product A*B, E4M3
- uio_out  output  8  tied to 8'h00
- uio_oe  output  8  tied to 8'h00 (all bidir pins are inputs)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high, on port rst_n.
- Format: bit7 = sign; bits6:3 = exponent E, bias 7; bits2:0 = mantissa M.
  - E=0: subnormal, value = M/8 * 2^-6.
  - E>0: value = (1+M/8) * 2^(E-7).
  - S.1111.111 is NaN. There is no infinity. Max finite = S.1111.110 = ±448.
- Reset: while rst_n=1 at a clk edge, uo_out <= 8'h00. Reset wins over ena.
- Otherwise, on each clk edge with ena=1: uo_out <= fp8_mul(ui_in, uio_in). Latency is 1 cycle.
- ena=0: uo_out holds its value.
- Combinational datapath:
  - Sign = A.s XOR B.s. Sign is preserved for zero results.
  - Either input NaN -> 8'h7F (canonical NaN, sign forced 0). NaN takes priority over zero.
  - Either input ±0 (E=0, M=0) with no NaN input -> signed zero.
  - Significands are 4-bit (implicit 1 for normals, 0 for subnormals), giving an 8-bit product. Unbiased exponent = eA + eB (subnormals use e = -6).
  - Normalize by a leading-one search over the 8-bit product; subnormal inputs may need a left shift.
  - Round to nearest, ties to even, using guard and sticky bits.
  - Mantissa overflow after rounding increments the exponent.
  - Overflow: a result exceeding 448 after rounding saturates to S.1111.110 (0x7E/0xFE). NaN is never produced from finite inputs.
  - Underflow: a result exponent below -6 is right-shifted into subnormal range, with sticky kept, then rounded with RNE.
    - Rounding up to 8/8 * 2^-6 yields the minimum normal S.0001.000.
    - Magnitude below 2^-10 flushes to signed zero; exactly 2^-10 rounds to even, i.e. zero.
- uio_out and uio_oe are constant 0 regardless of reset or ena.

Test Plan:
- Tiny subnormal products, uo_out sampled 1 cycle after each input change:
  - ui_in=0x03, uio_in=0x02 -> 0x00
  - 0x01 x 0x04 -> 0x00
  - 0x05 x 0x03 -> 0x00
  - 0x07 x 0x02 -> 0x00
  - 0x02 x 0x10 -> 0x00
  - 0x01 x 0x01 -> 0x00
- Normal arithmetic:
  - 0x38 x 0x38 (1x1) -> 0x38
  - 0x40 x 0x44 (2x3) -> 0x4C (6.0)
  - 0xB8 x 0x40 -> 0xC0 (-2.0)
- Rounding and subnormal output:
  - 0x39 x 0x39 (1.125^2 = 1.2656) -> 0x3A (RNE)
  - 0x38 x 0x01 -> 0x01
  - 0x30 x 0x08 (2^-1 x 2^-6) -> 0x04
- Specials:
  - 0x7E x 0x7E -> 0x7E (saturate)
  - 0xFE x 0x7E -> 0xFE
  - 0x7F x 0x38 -> 0x7F
  - 0x7F x 0x00 -> 0x7F
  - 0x80 x 0x38 -> 0x80
- Control:
  - rst_n=1 for one edge mid-stream -> uo_out=0x00 on that edge.
  - ena=0 with changing inputs -> uo_out unchanged.
  - uio_oe and uio_out = 0x00 at all times.

Source files
------------

// File: rtl/tt_um_light_fp8.sv
// Registered E4M3 (FN) multiplier: uo_out = round_rne(ui_in * uio_in), one cycle latency.
// Finite overflow saturates to +/-448; underflow goes through the subnormal range to signed zero.
module tt_um_light_fp8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic        sign;
    logic        is_nan;
    logic        is_zero;
    logic [3:0]  sig_a;
    logic [3:0]  sig_b;
    logic [3:0]  exp_a;
    logic [3:0]  exp_b;
    logic [7:0]  prod;
    logic [7:0]  prod_norm;
    logic [2:0]  lead;
    logic [5:0]  exp_sum;
    logic [4:0]  exp_base;
    logic [3:0]  shift;
    logic [15:0] wide;
    logic [3:0]  kept;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [8:0]  code;
    logic [8:0]  rounded;
    logic [6:0]  mag;
    logic [7:0]  result;
    logic [7:0]  result_q;

    always_comb begin
        sign    = ui_in[7] ^ uio_in[7];
        is_nan  = (ui_in[6:0] == 7'h7F) || (uio_in[6:0] == 7'h7F);
        is_zero = (ui_in[6:0] == 7'h00) || (uio_in[6:0] == 7'h00);

        sig_a = {ui_in[6:3] != 4'd0, ui_in[2:0]};
        sig_b = {uio_in[6:3] != 4'd0, uio_in[2:0]};
        // Subnormals share the exponent of the smallest normal.
        exp_a = (ui_in[6:3] == 4'd0) ? 4'd1 : ui_in[6:3];
        exp_b = (uio_in[6:3] == 4'd0) ? 4'd1 : uio_in[6:3];
        prod  = 8'(sig_a * sig_b);

        lead = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (prod[i]) begin
                lead = 3'(i);
            end
        end
        prod_norm = prod << (3'd7 - lead);

        // Biased result exponent is exp_sum - 13; it is normal when that is at least 1.
        exp_sum = 6'(exp_a) + 6'(exp_b) + 6'(lead);
        if (exp_sum >= 6'd14) begin
            exp_base = 5'(exp_sum - 6'd14);
            shift    = 4'd0;
        end else begin
            exp_base = 5'd0;
            shift    = 4'(6'd14 - exp_sum);
        end

        wide   = {prod_norm, 8'h00} >> shift;
        kept   = wide[15:12];
        guard  = wide[11];
        sticky = |wide[10:0];

        // Hidden bit in kept carries into the exponent field, so rounding overflow is free.
        code     = 9'({exp_base, 3'b000}) + 9'(kept);
        round_up = guard & (sticky | code[0]);
        rounded  = code + 9'(round_up);
        mag      = (rounded > 9'd126) ? 7'h7E : rounded[6:0];

        if (is_nan) begin
            result = 8'h7F;
        end else if (is_zero) begin
            result = {sign, 7'h00};
        end else begin
            result = {sign, mag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            result_q <= 8'h00;
        end else if (ena) begin
            result_q <= result;
        end
    end

    assign uo_out  = result_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_light_fp8.sv
// Bench for tt_um_light_fp8: directed vector table, control sequences, and random
// operands checked against a real-valued nearest-code reference.
module tb_tt_um_light_fp8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    tt_um_light_fp8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real decode_mag(input logic [7:0] x);
        int e;
        int m;
        e = int'(x[6:3]);
        m = int'(x[2:0]);
        if (e == 0) return (real'(m) / 8.0) * pow2(-6);
        return (1.0 + real'(m) / 8.0) * pow2(e - 7);
    endfunction

    // Nearest finite code to the exact product; ties go to the even code.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        real p;
        real d;
        real best_d;
        logic [7:0] best;
        logic [7:0] c;
        if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) return 8'h7F;
        p      = decode_mag(a) * decode_mag(b);
        best   = 8'h00;
        best_d = p;
        for (int i = 1; i <= 126; i++) begin
            c = 8'(i);
            d = decode_mag(c) - p;
            if (d < 0.0) d = -d;
            if (d < best_d || (d == best_d && c[0] == 1'b0)) begin
                best   = c;
                best_d = d;
            end
        end
        return {a[7] ^ b[7], best[6:0]};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive operands, let one edge pass, then sample away from the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b);
        ui_in  = a;
        uio_in = b;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[17];
    logic [7:0] held;
    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        vecs[0]  = '{8'h03, 8'h02, 8'h00};
        vecs[1]  = '{8'h01, 8'h04, 8'h00};
        vecs[2]  = '{8'h05, 8'h03, 8'h00};
        vecs[3]  = '{8'h07, 8'h02, 8'h00};
        vecs[4]  = '{8'h02, 8'h10, 8'h00};
        vecs[5]  = '{8'h01, 8'h01, 8'h00};
        vecs[6]  = '{8'h38, 8'h38, 8'h38};
        vecs[7]  = '{8'h40, 8'h44, 8'h4C};
        vecs[8]  = '{8'hB8, 8'h40, 8'hC0};
        vecs[9]  = '{8'h39, 8'h39, 8'h3A};
        vecs[10] = '{8'h38, 8'h01, 8'h01};
        vecs[11] = '{8'h30, 8'h08, 8'h04};
        vecs[12] = '{8'h7E, 8'h7E, 8'h7E};
        vecs[13] = '{8'hFE, 8'h7E, 8'hFE};
        vecs[14] = '{8'h7F, 8'h38, 8'h7F};
        vecs[15] = '{8'h7F, 8'h00, 8'h7F};
        vecs[16] = '{8'h80, 8'h38, 8'h80};

        // Reset state, with operands that would otherwise give a nonzero product.
        step(8'h38, 8'h38);
        step(8'h38, 8'h38);
        check("reset_state", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_%02hx_x_%02hx", i, vecs[i].a, vecs[i].b), uo_out,
                  vecs[i].exp);
        end

        // One-edge reset mid-stream.
        step(8'h40, 8'h44);
        check("pre_reset", uo_out, 8'h4C);
        rst_n = 1'b1;
        step(8'h38, 8'h38);
        check("mid_reset", uo_out, 8'h00);
        rst_n = 1'b0;
        step(8'h38, 8'h38);
        check("post_reset", uo_out, 8'h38);

        // Hold while disabled.
        step(8'h40, 8'h44);
        check("load_before_hold", uo_out, 8'h4C);
        ena = 1'b0;
        step(8'h38, 8'h38);
        check("hold_0", uo_out, 8'h4C);
        step(8'hFE, 8'h7E);
        check("hold_1", uo_out, 8'h4C);
        step(8'h7F, 8'h00);
        check("hold_2", uo_out, 8'h4C);

        // Reset wins over a low enable.
        rst_n = 1'b1;
        step(8'h38, 8'h38);
        check("reset_over_ena", uo_out, 8'h00);
        rst_n = 1'b0;
        ena   = 1'b1;

        held = 8'h00;
        step(8'h00, 8'h00);
        held = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            ena = ($urandom_range(0, 7) != 0);
            if (ena) held = ref_mul(ra, rb);
            step(ra, rb);
            check($sformatf("rand_%02hx_x_%02hx_ena%0d", ra, rb, ena), uo_out, held);
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                check("rand_uio", {uio_out | uio_oe}, 8'h00);
            end
        end
        check("final_uio_out", uio_out, 8'h00);
        check("final_uio_oe", uio_oe, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
